// File: rtl/pattern_det_pkg.sv
// Shared types and default sizing for the pattern detector scheduler.
// The top level and the window sub-module both import this package.
package pattern_det_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        REPORT
    } state_t;

endpackage

// File: rtl/pattern_window.sv
// Sliding bit window with fill tracking and a saturating match counter.
// A match needs a fully populated window, so the zeroed window after a clear cannot match.
module pattern_window
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int SEEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  window_shift;
    logic [SEEN_W-1:0] seen_cnt;
    logic [SEEN_W-1:0] seen_next;

    always_comb begin
        window_shift = (window << 1) | PAT_W'(bit_in);
        seen_next    = (seen_cnt == SEEN_W'(PAT_W)) ? seen_cnt : seen_cnt + 1'b1;
        match        = shift_en && (window_shift == pattern) && (seen_next == SEEN_W'(PAT_W));
    end

    // Without overlap the window restarts empty, so the next match needs PAT_W fresh bits.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            window    <= '0;
            seen_cnt  <= '0;
            match_cnt <= '0;
        end else if (shift_en) begin
            if (match && !overlap) begin
                window   <= '0;
                seen_cnt <= '0;
            end else begin
                window   <= window_shift;
                seen_cnt <= seen_next;
            end
            if (match && (match_cnt != '1)) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_det_sched.sv
// Round-robin scheduler granting one serial channel at a time to a pattern window
// and reporting the per-frame match count through a valid/ready result port.
module pattern_det_sched
    import pattern_det_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PAT_W-1:0]          cfg_pattern,
    input  logic                      cfg_overlap,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH-1:0]         req_bit,
    input  logic [NUM_CH-1:0]         req_last,
    output logic [NUM_CH-1:0]         req_ready,
    output logic                      res_valid,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]          res_count,
    input  logic                      res_ready,
    output logic                      busy
);

    localparam int CH_W = $clog2(NUM_CH);

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   next_ptr;
    logic              found;
    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic              accept;
    logic              clr;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  final_cnt;

    // First requester at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        pick  = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!found && req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        accept    = (state == STREAM) && req_valid[grant_ch] && req_ready[grant_ch];
        clr       = (state == IDLE) && (|req_valid);
        next_ptr  = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
        final_cnt = (match && (match_cnt != '1)) ? match_cnt + 1'b1 : match_cnt;
    end

    pattern_window #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .shift_en  (accept),
        .bit_in    (req_bit[grant_ch]),
        .pattern   (pat_q),
        .overlap   (ovl_q),
        .match     (match),
        .match_cnt (match_cnt)
    );

    // The result count is captured with the last beat's own match folded in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_ch  <= '0;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
            req_ready <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_count <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_ch  <= pick;
                        pat_q     <= cfg_pattern;
                        ovl_q     <= cfg_overlap;
                        req_ready <= NUM_CH'(1) << pick;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept && req_last[grant_ch]) begin
                        req_ready <= '0;
                        res_valid <= 1'b1;
                        res_ch    <= grant_ch;
                        res_count <= final_cnt;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_count <= '0;
                        busy      <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
